// File: rtl/mmio_trace_pkg.sv
// mmio_trace_pkg: shared types and constants for the MMIO write-trace monitor.
// The event record is sized for the largest supported channel count (8), so the
// channel field is always 3 bits wide regardless of how many channels are built.
package mmio_trace_pkg;

    localparam int TS_WIDTH  = 32;
    localparam int CNT_WIDTH = 16;

    typedef struct packed {
        logic [2:0]          channel;
        logic [3:0]          byteenable;
        logic [31:0]         data;
        logic [TS_WIDTH-1:0] timestamp;
    } trace_event_t;

    // Byte-lane merge: enabled lanes take the new word, disabled lanes keep the old one
    function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord,
                                               input logic [31:0] newWord,
                                               input logic [3:0]  byteEn);
        logic [31:0] result;
        for (int b = 0; b < 4; b++) begin
            result[8*b +: 8] = byteEn[b] ? newWord[8*b +: 8] : oldWord[8*b +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/mmio_trace_fifo.sv
// mmio_trace_fifo: show-ahead event queue. The head entry is visible on pop_data
// whenever the queue is non-empty and reads as zero when empty. A push into a full
// queue is accepted only when a pop happens in the same cycle.
module mmio_trace_fifo
    import mmio_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  trace_event_t             push_data,
    input  logic                     pop,
    output trace_event_t             pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);

    trace_event_t  mem_q [DEPTH];
    logic [PW-1:0] wrPtr_q;
    logic [PW-1:0] rdPtr_q;
    logic [PW:0]   level_q;
    logic          doPush;
    logic          doPop;

    assign empty    = (level_q == '0);
    assign full     = (level_q == (PW+1)'(DEPTH));
    assign doPop    = pop & ~empty;
    assign doPush   = push & (~full | doPop);
    assign level    = level_q;
    assign pop_data = empty ? '0 : mem_q[rdPtr_q];

    // Storage array; contents need no reset because the level gates visibility
    always_ff @(posedge clock) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + PW'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + PW'(1);
            if (doPush && !doPop)      level_q <= level_q + (PW+1)'(1);
            else if (doPop && !doPush) level_q <= level_q - (PW+1)'(1);
        end
    end

endmodule

// File: rtl/mmio_trace_monitor.sv
// mmio_trace_monitor: snoops a memory-mapped write bus, records writes that hit a
// watched address as timestamped trace events, keeps a byte-merged shadow copy and
// a saturating write count per channel, and counts events lost to a full queue.
// Optional feature: define MMIO_TRACE_DISPLAY_EN to print every matched write.
module mmio_trace_monitor
    import mmio_trace_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 29,
    parameter int          NUM_CHANNELS = 4,
    parameter logic [31:0] CH_BASE [NUM_CHANNELS] =
        '{32'h04000000, 32'h04000080, 32'h04000100, 32'h04000180},
    parameter int          FIFO_DEPTH   = 8,
    localparam int         CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int         LVL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                                    clock,
    input  logic                                    reset_n,
    input  logic [ADDR_WIDTH-1:0]                   bus_address,
    input  logic [3:0]                              bus_byteenable,
    input  logic                                    bus_write,
    input  logic                                    bus_waitrequest,
    input  logic [31:0]                             bus_writedata,
    input  logic                                    clear_stats,
    output logic                                    trace_valid,
    input  logic                                    trace_ready,
    output logic [CH_W-1:0]                         trace_channel,
    output logic [3:0]                              trace_byteenable,
    output logic [31:0]                             trace_data,
    output logic [31:0]                             trace_timestamp,
    output logic [NUM_CHANNELS-1:0][31:0]           shadow_data,
    output logic [NUM_CHANNELS-1:0][CNT_WIDTH-1:0]  write_count,
    output logic [CNT_WIDTH-1:0]                    drop_count,
    output logic                                    overflow,
    output logic [LVL_W-1:0]                        fifo_level
);

    logic [TS_WIDTH-1:0]                   timestamp_q;
    logic [NUM_CHANNELS-1:0][31:0]         shadow_q, shadow_d;
    logic [NUM_CHANNELS-1:0][CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0]                  drop_q, drop_d;
    logic                                  overflow_q, overflow_d;

    logic [31:0]  byteAddr;
    logic         accept;
    logic         hit;
    logic [2:0]   hitChannel;
    logic         pushReq;
    logic         popFire;
    logic         dropEvent;
    logic         fifoFull;
    logic         fifoEmpty;
    logic         unusedChannelBits;
    trace_event_t pushEvent;
    trace_event_t headEvent;

    assign byteAddr  = 32'({bus_address, 2'b00});
    assign accept    = bus_write & ~bus_waitrequest;
    assign pushReq   = accept & hit;
    assign popFire   = ~fifoEmpty & trace_ready;
    assign dropEvent = pushReq & fifoFull & ~popFire;

    assign pushEvent = '{channel: hitChannel, byteenable: bus_byteenable,
                         data: bus_writedata, timestamp: timestamp_q};

    // Address decode; scanning upward and stopping at the first hit gives the lowest channel priority
    always_comb begin
        hit        = 1'b0;
        hitChannel = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (!hit && byteAddr == CH_BASE[i]) begin
                hit        = 1'b1;
                hitChannel = 3'(i);
            end
        end
    end

    // Statistics next state; a clear overrides any increment in the same cycle
    always_comb begin
        shadow_d   = shadow_q;
        count_d    = count_q;
        drop_d     = drop_q;
        overflow_d = overflow_q;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (pushReq && hitChannel == 3'(i)) begin
                shadow_d[i] = mergeBytes(shadow_q[i], bus_writedata, bus_byteenable);
                if (count_q[i] != '1) count_d[i] = count_q[i] + CNT_WIDTH'(1);
            end
        end
        if (dropEvent) begin
            if (drop_q != '1) drop_d = drop_q + CNT_WIDTH'(1);
            overflow_d = 1'b1;
        end
        if (clear_stats) begin
            count_d    = '0;
            drop_d     = '0;
            overflow_d = 1'b0;
        end
    end

    // Free-running timestamp and statistics registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timestamp_q <= '0;
            shadow_q    <= '0;
            count_q     <= '0;
            drop_q      <= '0;
            overflow_q  <= 1'b0;
        end else begin
            timestamp_q <= timestamp_q + TS_WIDTH'(1);
            shadow_q    <= shadow_d;
            count_q     <= count_d;
            drop_q      <= drop_d;
            overflow_q  <= overflow_d;
        end
    end

    mmio_trace_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (pushReq),
        .push_data (pushEvent),
        .pop       (popFire),
        .pop_data  (headEvent),
        .full      (fifoFull),
        .empty     (fifoEmpty),
        .level     (fifo_level)
    );

    assign unusedChannelBits = ^headEvent.channel;
    assign trace_valid       = ~fifoEmpty;
    assign trace_channel     = headEvent.channel[CH_W-1:0];
    assign trace_byteenable  = headEvent.byteenable;
    assign trace_data        = headEvent.data;
    assign trace_timestamp   = headEvent.timestamp;
    assign shadow_data       = shadow_q;
    assign write_count       = count_q;
    assign drop_count        = drop_q;
    assign overflow          = overflow_q;

`ifdef MMIO_TRACE_DISPLAY_EN
    // Report every matched accepted write, including those the full queue drops
    always_ff @(posedge clock) begin
        if (reset_n && pushReq) begin
            $display("CH%0d write, address %h, data %h", hitChannel, byteAddr, bus_writedata);
        end
    end
`else
    // Default build carries no reporting logic
`endif

endmodule

// File: tb/tb_mmio_trace_monitor.sv
// tb_mmio_trace_monitor: drives directed and randomized bus traffic into
// mmio_trace_monitor and compares every output against a queue-based model.
module tb_mmio_trace_monitor;

    localparam int ADDR_WIDTH   = 29;
    localparam int NUM_CHANNELS = 4;
    localparam int FIFO_DEPTH   = 8;
    localparam logic [31:0] BASES [NUM_CHANNELS] =
        '{32'h04000000, 32'h04000080, 32'h04000100, 32'h04000180};

    logic                         clock = 1'b0;
    logic                         reset_n = 1'b0;
    logic [ADDR_WIDTH-1:0]        bus_address = '0;
    logic [3:0]                   bus_byteenable = '0;
    logic                         bus_write = 1'b0;
    logic                         bus_waitrequest = 1'b0;
    logic [31:0]                  bus_writedata = '0;
    logic                         clear_stats = 1'b0;
    logic                         trace_ready = 1'b0;
    logic                         trace_valid;
    logic [1:0]                   trace_channel;
    logic [3:0]                   trace_byteenable;
    logic [31:0]                  trace_data;
    logic [31:0]                  trace_timestamp;
    logic [NUM_CHANNELS-1:0][31:0] shadow_data;
    logic [NUM_CHANNELS-1:0][15:0] write_count;
    logic [15:0]                  drop_count;
    logic                         overflow;
    logic [3:0]                   fifo_level;

    typedef struct {
        int unsigned ch;
        logic [3:0]  be;
        logic [31:0] data;
        logic [31:0] ts;
    } evModel_t;

    evModel_t    evq[$];
    logic [31:0] mShadow [NUM_CHANNELS];
    int unsigned mCount  [NUM_CHANNELS];
    int unsigned mDrop;
    bit          mOvf;
    logic [31:0] mTs;
    int          checks = 0;
    int          failures = 0;

    mmio_trace_monitor #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .NUM_CHANNELS (NUM_CHANNELS),
        .CH_BASE      (BASES),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .bus_address      (bus_address),
        .bus_byteenable   (bus_byteenable),
        .bus_write        (bus_write),
        .bus_waitrequest  (bus_waitrequest),
        .bus_writedata    (bus_writedata),
        .clear_stats      (clear_stats),
        .trace_valid      (trace_valid),
        .trace_ready      (trace_ready),
        .trace_channel    (trace_channel),
        .trace_byteenable (trace_byteenable),
        .trace_data       (trace_data),
        .trace_timestamp  (trace_timestamp),
        .shadow_data      (shadow_data),
        .write_count      (write_count),
        .drop_count       (drop_count),
        .overflow         (overflow),
        .fifo_level       (fifo_level)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        evq.delete();
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            mShadow[i] = '0;
            mCount[i]  = 0;
        end
        mDrop = 0;
        mOvf  = 1'b0;
        mTs   = '0;
    endtask

    // One clock of the reference model, evaluated on the inputs held across the edge
    task automatic stepModel();
        bit       popFire;
        bit       pushOk;
        int       hitCh;
        evModel_t e;
        popFire = (evq.size() > 0) && trace_ready;
        pushOk  = 1'b0;
        hitCh   = -1;
        if (bus_write && !bus_waitrequest) begin
            for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
                if ((32'(bus_address) << 2) == BASES[i]) hitCh = i;
            end
        end
        if (hitCh >= 0) begin
            for (int b = 0; b < 4; b++) begin
                if (bus_byteenable[b]) mShadow[hitCh][8*b +: 8] = bus_writedata[8*b +: 8];
            end
            if (mCount[hitCh] < 65535) mCount[hitCh]++;
            e.ch   = hitCh;
            e.be   = bus_byteenable;
            e.data = bus_writedata;
            e.ts   = mTs;
            if (evq.size() < FIFO_DEPTH || popFire) begin
                pushOk = 1'b1;
            end else begin
                if (mDrop < 65535) mDrop++;
                mOvf = 1'b1;
            end
        end
        if (clear_stats) begin
            for (int i = 0; i < NUM_CHANNELS; i++) mCount[i] = 0;
            mDrop = 0;
            mOvf  = 1'b0;
        end
        if (popFire) void'(evq.pop_front());
        if (pushOk) evq.push_back(e);
        mTs = mTs + 32'd1;
    endtask

    task automatic checkState();
        logic [127:0] expShadow;
        logic [127:0] expCount;
        expShadow = '0;
        expCount  = '0;
        checkOutput("trace_valid", trace_valid, evq.size() > 0);
        checkOutput("fifo_level", fifo_level, evq.size());
        if (evq.size() > 0) begin
            checkOutput("trace_channel", trace_channel, evq[0].ch);
            checkOutput("trace_byteenable", trace_byteenable, evq[0].be);
            checkOutput("trace_data", trace_data, evq[0].data);
            checkOutput("trace_timestamp", trace_timestamp, evq[0].ts);
        end
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            expShadow[32*i +: 32] = mShadow[i];
            expCount[16*i +: 16]  = 16'(mCount[i]);
        end
        checkOutput("shadow_data", shadow_data, expShadow);
        checkOutput("write_count", write_count, expCount);
        checkOutput("drop_count", drop_count, 16'(mDrop));
        checkOutput("overflow", overflow, mOvf);
    endtask

    // Drive one cycle of inputs, advance model and DUT together, then compare
    task automatic applyStimulus(input bit wr, input bit wt, input logic [ADDR_WIDTH-1:0] addr,
                                 input logic [3:0] be, input logic [31:0] data,
                                 input bit rdy, input bit clr);
        bus_write       = wr;
        bus_waitrequest = wt;
        bus_address     = addr;
        bus_byteenable  = be;
        bus_writedata   = data;
        trace_ready     = rdy;
        clear_stats     = clr;
        stepModel();
        @(posedge clock);
        #1;
        checkState();
    endtask

    function automatic logic [ADDR_WIDTH-1:0] chAddr(input int ch);
        return ADDR_WIDTH'(BASES[ch] >> 2);
    endfunction

    task automatic drain();
        for (int n = 0; n < FIFO_DEPTH + 2 && evq.size() > 0; n++) begin
            applyStimulus(0, 0, '0, 4'h0, '0, 1, 0);
        end
        checkOutput("drain empty", fifo_level, 0);
    endtask

    initial begin
        logic [31:0] acceptTs;
        bit          rdyBias;

        modelReset();
        repeat (2) @(posedge clock);
        #1;
        checkState();
        checkOutput("reset trace_data", trace_data, 0);
        checkOutput("reset trace_timestamp", trace_timestamp, 0);
        reset_n = 1'b1;

        // Single full-word write to channel 0
        applyStimulus(1, 0, 29'h01000000, 4'hF, 32'h0000002A, 0, 0);
        checkOutput("ch0 event data", trace_data, 32'h0000002A);
        checkOutput("ch0 event channel", trace_channel, 0);
        checkOutput("ch0 shadow", shadow_data[0], 32'h0000002A);
        checkOutput("ch0 write_count", write_count[0], 1);
        drain();

        // Byte-lane merge on channel 1
        applyStimulus(1, 0, chAddr(1), 4'hF, 32'h11223344, 1, 0);
        applyStimulus(1, 0, chAddr(1), 4'b0010, 32'hAABBCCDD, 1, 0);
        checkOutput("ch1 merged shadow", shadow_data[1], 32'h1122CC44);
        drain();

        // Wait-stated write produces exactly one event stamped with the accept cycle
        repeat (3) applyStimulus(1, 1, chAddr(2), 4'hF, 32'hCAFE0002, 0, 0);
        checkOutput("waited no event", fifo_level, 0);
        acceptTs = mTs;
        applyStimulus(1, 0, chAddr(2), 4'hF, 32'hCAFE0002, 0, 0);
        applyStimulus(0, 0, '0, 4'h0, '0, 0, 0);
        checkOutput("waited one event", fifo_level, 1);
        checkOutput("waited timestamp", trace_timestamp, acceptTs);
        drain();

        // Overflow: ten writes with no consumer, then drain in order
        applyStimulus(0, 0, '0, 4'h0, '0, 0, 1);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1, 0, chAddr(k % NUM_CHANNELS), 4'hF, 32'h100 + k, 0, 0);
        end
        checkOutput("overflow level", fifo_level, 8);
        checkOutput("overflow drops", drop_count, 2);
        checkOutput("overflow flag", overflow, 1);
        drain();

        // Full queue with simultaneous push and pop
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            applyStimulus(1, 0, chAddr(3), 4'hF, 32'h200 + k, 0, 0);
        end
        applyStimulus(1, 0, chAddr(0), 4'h3, 32'h0000BEEF, 1, 0);
        checkOutput("push+pop level", fifo_level, 8);
        checkOutput("push+pop drops", drop_count, 2);
        drain();

        // Clear coinciding with a matched write
        applyStimulus(1, 0, chAddr(2), 4'hF, 32'h33333333, 0, 1);
        checkOutput("clear wins count", write_count[2], 0);
        checkOutput("clear keeps event", fifo_level, 1);
        applyStimulus(1, 0, chAddr(1), 4'hF, 32'h44444444, 0, 0);
        applyStimulus(1, 0, chAddr(0), 4'hF, 32'h55555555, 0, 0);
        checkOutput("three queued", fifo_level, 3);

        // Asynchronous reset mid-operation
        bus_write = 1'b0;
        reset_n   = 1'b0;
        #1;
        modelReset();
        checkOutput("async reset level", fifo_level, 0);
        checkOutput("async reset valid", trace_valid, 0);
        checkOutput("async reset data", trace_data, 0);
        checkState();
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Randomized traffic with varying consumer pressure
        for (int n = 0; n < 400; n++) begin
            logic [ADDR_WIDTH-1:0] addr;
            if (n % 50 == 0) rdyBias = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) != 0) addr = chAddr($urandom_range(0, NUM_CHANNELS - 1));
            else addr = ADDR_WIDTH'($urandom);
            applyStimulus($urandom_range(0, 9) < 6,
                          $urandom_range(0, 3) == 0,
                          addr,
                          4'($urandom),
                          $urandom,
                          rdyBias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0),
                          $urandom_range(0, 31) == 0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
